// File: rtl/re_mapper_pkg.sv
// Shared types, defaults and the configuration check for the resource-element mapper.
package re_mapper_pkg;

  localparam int NSC_TOT_DEF = 1200;
  localparam int NSYM_DEF    = 14;
  localparam int RE_PER_RB   = 12;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    SYM_INIT,
    MAP_DMRS,
    MAP_DATA,
    SYM_END,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    SRC_FFT,
    SRC_DMRS,
    SRC_ZERO
  } wr_src_t;

  // Fields are sized for the widest supported grid; narrower ports are zero-extended.
  typedef struct packed {
    logic [15:0] sc_start;
    logic [6:0]  n_rb;
    logic [3:0]  sym_start;
    logic [3:0]  sym_end;
    logic [15:0] dmrs_mask;
    logic        comb;
  } cfg_t;

  function automatic logic [10:0] n_sc_of(logic [6:0] n_rb);
    return 11'(n_rb) * 11'(RE_PER_RB);
  endfunction

  function automatic logic cfg_check(cfg_t cfg, int nsc_tot, int nsym);
    int sc_end;
    sc_end = int'(cfg.sc_start) + int'(n_sc_of(cfg.n_rb));
    return (cfg.n_rb == 7'd0) || (cfg.sym_end < cfg.sym_start) ||
           (int'(cfg.sym_end) >= nsym) || (sc_end > nsc_tot);
  endfunction

endpackage

// File: rtl/re_mapper_gen_if.sv
// FFT / DMRS input streams and grid write bus of the resource-element mapper.
interface re_mapper_gen_if #(
  parameter int IQ_W   = 18,
  parameter int DMRS_W = 9,
  parameter int ADDR_W = 11
);
  logic signed [IQ_W-1:0]   fft_i;
  logic signed [IQ_W-1:0]   fft_q;
  logic                     fft_valid;
  logic                     fft_ready;
  logic signed [DMRS_W-1:0] dmrs_i;
  logic signed [DMRS_W-1:0] dmrs_q;
  logic                     dmrs_valid;
  logic                     dmrs_ready;
  logic [9:0]               dmrs_rd_addr;
  logic                     wr_en;
  logic [3:0]               wr_sym;
  logic [ADDR_W-1:0]        wr_addr;
  logic signed [IQ_W-1:0]   wr_i;
  logic signed [IQ_W-1:0]   wr_q;

  modport master (
    output fft_i, fft_q, fft_valid, dmrs_i, dmrs_q, dmrs_valid,
    input  fft_ready, dmrs_ready, dmrs_rd_addr,
    input  wr_en, wr_sym, wr_addr, wr_i, wr_q
  );

  modport slave (
    input  fft_i, fft_q, fft_valid, dmrs_i, dmrs_q, dmrs_valid,
    output fft_ready, dmrs_ready, dmrs_rd_addr,
    output wr_en, wr_sym, wr_addr, wr_i, wr_q
  );
endinterface

// File: rtl/re_mapper_wr_stage.sv
// Registered grid write stage: selects FFT, sign-extended DMRS or zero data.
module re_mapper_wr_stage
  import re_mapper_pkg::*;
#(
  parameter int IQ_W   = 18,
  parameter int DMRS_W = 9,
  parameter int ADDR_W = 11
) (
  input  logic                     CLK_RE,
  input  logic                     RST_RE,
  input  logic                     wr_req,
  input  wr_src_t                  wr_src,
  input  logic signed [IQ_W-1:0]   fft_i,
  input  logic signed [IQ_W-1:0]   fft_q,
  input  logic signed [DMRS_W-1:0] dmrs_i,
  input  logic signed [DMRS_W-1:0] dmrs_q,
  input  logic [3:0]               sym,
  input  logic [ADDR_W-1:0]        addr,
  output logic                     wr_en,
  output logic [3:0]               wr_sym,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic signed [IQ_W-1:0]   wr_i,
  output logic signed [IQ_W-1:0]   wr_q
);

  logic signed [IQ_W-1:0] data_i;
  logic signed [IQ_W-1:0] data_q;

  always_comb begin
    data_i = '0;
    data_q = '0;
    case (wr_src)
      SRC_FFT: begin
        data_i = fft_i;
        data_q = fft_q;
      end
      SRC_DMRS: begin
        data_i = {{(IQ_W-DMRS_W){dmrs_i[DMRS_W-1]}}, dmrs_i};
        data_q = {{(IQ_W-DMRS_W){dmrs_q[DMRS_W-1]}}, dmrs_q};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_RE or posedge RST_RE) begin
    if (RST_RE) begin
      wr_en   <= 1'b0;
      wr_sym  <= '0;
      wr_addr <= '0;
      wr_i    <= '0;
      wr_q    <= '0;
    end else begin
      wr_en <= wr_req;
      if (wr_req) begin
        wr_sym  <= sym;
        wr_addr <= addr;
        wr_i    <= data_i;
        wr_q    <= data_q;
      end
    end
  end

endmodule

// File: rtl/re_mapper_gen.sv
// PUSCH resource-element mapper with DMRS bitmap, comb offset and back-pressure.
// Define RE_MAPPER_ZERO_FILL_EN to write zeros on non-DMRS REs of DMRS symbols.
module re_mapper_gen
  import re_mapper_pkg::*;
#(
  parameter int IQ_W    = 18,
  parameter int DMRS_W  = 9,
  parameter int NSC_TOT = NSC_TOT_DEF,
  parameter int NSYM    = NSYM_DEF,
  parameter int ADDR_W  = 11
) (
  input  logic              CLK_RE,
  input  logic              RST_RE,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_sc_start,
  input  logic [6:0]        cfg_n_rb,
  input  logic [3:0]        cfg_sym_start,
  input  logic [3:0]        cfg_sym_end,
  input  logic [NSYM-1:0]   cfg_dmrs_mask,
  input  logic              cfg_comb,
  re_mapper_gen_if.slave    bus,
  output logic              busy,
  output logic              sym_done,
  output logic              slot_done,
  output logic              cfg_err
);

  state_t            state, next_state;
  cfg_t              cfg_q, cfg_in;
  logic [3:0]        sym_q;
  logic [10:0]       sc_cnt_q;
  logic [10:0]       n_sc;
  logic [10:0]       sc_inc;
  logic [9:0]        dmrs_cnt_q;
  logic              cfg_bad, sym_is_dmrs, sym_is_last, dmrs_re;
  logic              re_last, wr_req, fft_rdy, dmrs_rdy, dmrs_take;
  wr_src_t           wr_src;
  logic [ADDR_W-1:0] wr_addr_nxt;

  always_comb begin
    cfg_in           = '0;
    cfg_in.sc_start  = 16'(cfg_sc_start);
    cfg_in.n_rb      = cfg_n_rb;
    cfg_in.sym_start = cfg_sym_start;
    cfg_in.sym_end   = cfg_sym_end;
    cfg_in.dmrs_mask = 16'(cfg_dmrs_mask);
    cfg_in.comb      = cfg_comb;
  end

  assign n_sc        = n_sc_of(cfg_q.n_rb);
  assign cfg_bad     = cfg_check(cfg_q, NSC_TOT, NSYM);
  assign sym_is_dmrs = cfg_q.dmrs_mask[sym_q];
  assign sym_is_last = (sym_q == cfg_q.sym_end);
  assign dmrs_re     = (sc_cnt_q[0] == cfg_q.comb);
  assign wr_addr_nxt = ADDR_W'(cfg_q.sc_start) + ADDR_W'(sc_cnt_q);

  always_ff @(posedge CLK_RE or posedge RST_RE) begin
    if (RST_RE) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:     if (cfg_start) next_state = CHECK;
      CHECK:    next_state = cfg_bad ? IDLE : SYM_INIT;
      SYM_INIT: next_state = sym_is_dmrs ? MAP_DMRS : MAP_DATA;
      MAP_DMRS,
      MAP_DATA: if (re_last) next_state = SYM_END;
      SYM_END:  next_state = sym_is_last ? DONE : SYM_INIT;
      DONE:     next_state = IDLE;
      default:  next_state = IDLE;
    endcase
  end

  always_comb begin
    fft_rdy   = 1'b0;
    dmrs_rdy  = 1'b0;
    wr_req    = 1'b0;
    wr_src    = SRC_FFT;
    sc_inc    = '0;
    dmrs_take = 1'b0;
    re_last   = 1'b0;
    case (state)
      MAP_DATA: begin
        fft_rdy = 1'b1;
        if (bus.fft_valid) begin
          wr_req  = 1'b1;
          sc_inc  = 11'd1;
          re_last = (sc_cnt_q == n_sc - 11'd1);
        end
      end
      MAP_DMRS: begin
        dmrs_rdy = dmrs_re;
`ifdef RE_MAPPER_ZERO_FILL_EN
        if (!dmrs_re) begin
          wr_req  = 1'b1;
          wr_src  = SRC_ZERO;
          sc_inc  = 11'd1;
          re_last = (sc_cnt_q == n_sc - 11'd1);
        end else if (bus.dmrs_valid) begin
          wr_req    = 1'b1;
          wr_src    = SRC_DMRS;
          dmrs_take = 1'b1;
          sc_inc    = 11'd1;
          re_last   = (sc_cnt_q == n_sc - 11'd1);
        end
`else
        // Only an odd comb starts off-comb; one skip cycle aligns, then step by two.
        if (!dmrs_re) begin
          sc_inc = 11'd1;
        end else if (bus.dmrs_valid) begin
          wr_req    = 1'b1;
          wr_src    = SRC_DMRS;
          dmrs_take = 1'b1;
          sc_inc    = 11'd2;
          re_last   = (sc_cnt_q >= n_sc - 11'd2);
        end
`endif
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_RE or posedge RST_RE) begin
    if (RST_RE) begin
      cfg_q      <= '0;
      cfg_err    <= 1'b0;
      sym_q      <= '0;
      sc_cnt_q   <= '0;
      dmrs_cnt_q <= '0;
      busy       <= 1'b0;
      sym_done   <= 1'b0;
      slot_done  <= 1'b0;
    end else begin
      sym_done  <= (state == SYM_END);
      slot_done <= (state == DONE);
      busy      <= (next_state != IDLE) && (next_state != CHECK);
      case (state)
        IDLE: begin
          if (cfg_start) begin
            cfg_q   <= cfg_in;
            cfg_err <= 1'b0;
          end
        end
        CHECK: begin
          if (cfg_bad) cfg_err <= 1'b1;
          else         sym_q   <= cfg_q.sym_start;
        end
        SYM_INIT: begin
          sc_cnt_q   <= '0;
          dmrs_cnt_q <= '0;
        end
        MAP_DMRS, MAP_DATA: begin
          sc_cnt_q <= sc_cnt_q + sc_inc;
          if (dmrs_take) dmrs_cnt_q <= dmrs_cnt_q + 10'd1;
        end
        SYM_END: begin
          if (!sym_is_last) sym_q <= sym_q + 4'd1;
        end
        default: ;
      endcase
    end
  end

  assign bus.fft_ready    = fft_rdy;
  assign bus.dmrs_ready   = dmrs_rdy;
  assign bus.dmrs_rd_addr = dmrs_cnt_q;

  re_mapper_wr_stage #(
    .IQ_W  (IQ_W),
    .DMRS_W(DMRS_W),
    .ADDR_W(ADDR_W)
  ) u_wr_stage (
    .CLK_RE (CLK_RE),
    .RST_RE (RST_RE),
    .wr_req (wr_req),
    .wr_src (wr_src),
    .fft_i  (bus.fft_i),
    .fft_q  (bus.fft_q),
    .dmrs_i (bus.dmrs_i),
    .dmrs_q (bus.dmrs_q),
    .sym    (sym_q),
    .addr   (wr_addr_nxt),
    .wr_en  (bus.wr_en),
    .wr_sym (bus.wr_sym),
    .wr_addr(bus.wr_addr),
    .wr_i   (bus.wr_i),
    .wr_q   (bus.wr_q)
  );

endmodule

// File: tb/tb_re_mapper_gen.sv
// Randomized bench for re_mapper_gen against a list-of-writes reference model.
module tb_re_mapper_gen;

  localparam int IQ_W    = 18;
  localparam int DMRS_W  = 9;
  localparam int NSC_TOT = 1200;
  localparam int NSYM    = 14;
  localparam int ADDR_W  = 11;

  logic              CLK_RE = 1'b0;
  logic              RST_RE;
  logic              cfg_start;
  logic [ADDR_W-1:0] cfg_sc_start;
  logic [6:0]        cfg_n_rb;
  logic [3:0]        cfg_sym_start;
  logic [3:0]        cfg_sym_end;
  logic [NSYM-1:0]   cfg_dmrs_mask;
  logic              cfg_comb;
  logic              busy, sym_done, slot_done, cfg_err;

  re_mapper_gen_if #(.IQ_W(IQ_W), .DMRS_W(DMRS_W), .ADDR_W(ADDR_W)) bus ();

  re_mapper_gen #(
    .IQ_W(IQ_W), .DMRS_W(DMRS_W), .NSC_TOT(NSC_TOT), .NSYM(NSYM), .ADDR_W(ADDR_W)
  ) dut (
    .CLK_RE       (CLK_RE),
    .RST_RE       (RST_RE),
    .cfg_start    (cfg_start),
    .cfg_sc_start (cfg_sc_start),
    .cfg_n_rb     (cfg_n_rb),
    .cfg_sym_start(cfg_sym_start),
    .cfg_sym_end  (cfg_sym_end),
    .cfg_dmrs_mask(cfg_dmrs_mask),
    .cfg_comb     (cfg_comb),
    .bus          (bus),
    .busy         (busy),
    .sym_done     (sym_done),
    .slot_done    (slot_done),
    .cfg_err      (cfg_err)
  );

  initial forever #5 CLK_RE = ~CLK_RE;

  typedef struct {
    int sym;
    int addr;
    int di;
    int dq;
  } wr_t;

  wr_t exp_q[$];
  int  exp_dm[$];
  int  f_i[$], f_q[$], d_i[$], d_q[$];
  int  checks = 0, errors = 0;
  int  wr_cnt = 0, sd_cnt = 0, slot_cnt = 0;
  bit  drv_stop = 1'b1;
  int  vmode = 0;

  task automatic checkOutput(string tag, int actual, int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  function automatic bit pickValid(int cyc);
    if (vmode == 1) return (cyc % 2) == 0;
    if (vmode == 2) return 1'b1;
    return $urandom_range(0, 3) != 0;
  endfunction

  // Reference: the ordered list of grid writes a slot must produce, independent of timing.
  task automatic buildModel(int sc, int nrb, int s0, int s1, int mask, int comb, output bit err);
    int n_sc;
    n_sc = nrb * 12;
    err  = (nrb == 0) || (s1 < s0) || (s1 >= NSYM) || (sc + n_sc > NSC_TOT);
    exp_q.delete(); exp_dm.delete();
    f_i.delete(); f_q.delete(); d_i.delete(); d_q.delete();
    if (!err) begin
      for (int s = s0; s <= s1; s++) begin
        int ndm = 0;
        for (int k = 0; k < n_sc; k++) begin
          int vi, vq;
          if (((mask >> s) & 1) == 1) begin
            if ((k % 2) == comb) begin
              vi = int'($urandom_range(0, 511)) - 256;
              vq = int'($urandom_range(0, 511)) - 256;
              d_i.push_back(vi); d_q.push_back(vq);
              exp_q.push_back('{s, sc + k, vi, vq});
              ndm++;
            end else begin
`ifdef RE_MAPPER_ZERO_FILL_EN
              exp_q.push_back('{s, sc + k, 0, 0});
`endif
            end
          end else begin
            vi = int'($urandom_range(0, 262143)) - 131072;
            vq = int'($urandom_range(0, 262143)) - 131072;
            f_i.push_back(vi); f_q.push_back(vq);
            exp_q.push_back('{s, sc + k, vi, vq});
          end
        end
        exp_dm.push_back(ndm);
      end
    end
  endtask

  task automatic driveStreams();
    int fi = 0, di = 0, cyc = 0;
    while (!drv_stop) begin
      bit take_f, take_d;
      @(negedge CLK_RE);
      take_f = bus.fft_valid && bus.fft_ready;
      take_d = bus.dmrs_valid && bus.dmrs_ready;
      @(posedge CLK_RE); #1;
      if (take_f) fi++;
      if (take_d) di++;
      cyc++;
      if (fi < f_i.size() && !drv_stop) begin
        bus.fft_i = IQ_W'(f_i[fi]); bus.fft_q = IQ_W'(f_q[fi]);
        bus.fft_valid = pickValid(cyc);
      end else bus.fft_valid = 1'b0;
      if (di < d_i.size() && !drv_stop) begin
        bus.dmrs_i = DMRS_W'(d_i[di]); bus.dmrs_q = DMRS_W'(d_q[di]);
        bus.dmrs_valid = pickValid(cyc + 1);
      end else bus.dmrs_valid = 1'b0;
    end
    bus.fft_valid  = 1'b0;
    bus.dmrs_valid = 1'b0;
  endtask

  always @(negedge CLK_RE) begin : monitor
    wr_t e;
    if (!RST_RE) begin
      if (bus.wr_en) begin
        wr_cnt++;
        if (exp_q.size() == 0) checkOutput("extra_wr", 1, 0);
        else begin
          e = exp_q.pop_front();
          checkOutput("wr_sym", int'(bus.wr_sym), e.sym);
          checkOutput("wr_addr", int'(bus.wr_addr), e.addr);
          checkOutput("wr_i", int'(bus.wr_i), e.di);
          checkOutput("wr_q", int'(bus.wr_q), e.dq);
        end
      end
      if (sym_done) begin
        sd_cnt++;
        if (exp_dm.size() == 0) checkOutput("extra_sym_done", 1, 0);
        else checkOutput("dmrs_rd_addr", int'(bus.dmrs_rd_addr), exp_dm.pop_front());
      end
      if (slot_done) slot_cnt++;
    end
  end

  task automatic startSlot(int sc, int nrb, int s0, int s1, int mask, int comb, int vm,
                           output bit err, output int nexp);
    buildModel(sc, nrb, s0, s1, mask, comb, err);
    nexp = exp_q.size();
    vmode = vm; wr_cnt = 0; sd_cnt = 0; slot_cnt = 0; drv_stop = 1'b0;
    fork driveStreams(); join_none
    @(posedge CLK_RE); #1;
    cfg_sc_start  = ADDR_W'(sc);
    cfg_n_rb      = 7'(nrb);
    cfg_sym_start = 4'(s0);
    cfg_sym_end   = 4'(s1);
    cfg_dmrs_mask = NSYM'(mask);
    cfg_comb      = 1'(comb);
    cfg_start     = 1'b1;
    @(posedge CLK_RE); #1;
    cfg_start = 1'b0;
  endtask

  task automatic applyStimulus(int sc, int nrb, int s0, int s1, int mask, int comb, int vm);
    bit err;
    int nexp, budget;
    bit busy_seen = 1'b0;
    startSlot(sc, nrb, s0, s1, mask, comb, vm, err, nexp);
    if (err) begin
      repeat (6) @(posedge CLK_RE);
      #2;
      checkOutput("cfg_err_set", int'(cfg_err), 1);
      checkOutput("busy_err", int'(busy), 0);
    end else begin
      budget = 100 + (s1 - s0 + 1) * nrb * 12 * 8;
      for (int c = 0; c < budget && slot_cnt == 0; c++) begin
        @(posedge CLK_RE); #2;
        if (busy) busy_seen = 1'b1;
      end
      if (slot_cnt == 0) checkOutput("slot_timeout", 0, 1);
      repeat (2) @(posedge CLK_RE);
      #2;
      checkOutput("cfg_err_clr", int'(cfg_err), 0);
      checkOutput("busy_seen", int'(busy_seen), 1);
      checkOutput("busy_end", int'(busy), 0);
    end
    checkOutput("wr_count", wr_cnt, nexp);
    checkOutput("sym_done_cnt", sd_cnt, err ? 0 : s1 - s0 + 1);
    checkOutput("slot_done_cnt", slot_cnt, err ? 0 : 1);
    drv_stop = 1'b1;
    repeat (3) @(posedge CLK_RE);
  endtask

  task automatic resetMidSlot();
    bit err;
    int nexp, w0;
    startSlot(50, 2, 4, 4, 0, 0, 2, err, nexp);
    for (int c = 0; c < 500 && wr_cnt < 5; c++) @(posedge CLK_RE);
    #3;
    RST_RE = 1'b1;
    #1;
    checkOutput("rst_wr_en", int'(bus.wr_en), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_fft_ready", int'(bus.fft_ready), 0);
    drv_stop = 1'b1;
    exp_q.delete(); exp_dm.delete();
    w0 = wr_cnt;
    repeat (4) @(posedge CLK_RE);
    #1 RST_RE = 1'b0;
    repeat (4) @(posedge CLK_RE);
    #2;
    checkOutput("wr_after_rst", wr_cnt - w0, 0);
    checkOutput("busy_after_rst", int'(busy), 0);
  endtask

  initial begin
    RST_RE = 1'b1; cfg_start = 1'b0; cfg_sc_start = '0; cfg_n_rb = '0;
    cfg_sym_start = '0; cfg_sym_end = '0; cfg_dmrs_mask = '0; cfg_comb = 1'b0;
    bus.fft_i = '0; bus.fft_q = '0; bus.fft_valid = 1'b0;
    bus.dmrs_i = '0; bus.dmrs_q = '0; bus.dmrs_valid = 1'b0;
    repeat (3) @(posedge CLK_RE);
    #2;
    checkOutput("rst_wr_en", int'(bus.wr_en), 0);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_sym_done", int'(sym_done), 0);
    checkOutput("rst_slot_done", int'(slot_done), 0);
    checkOutput("rst_cfg_err", int'(cfg_err), 0);
    checkOutput("rst_fft_ready", int'(bus.fft_ready), 0);
    checkOutput("rst_dmrs_ready", int'(bus.dmrs_ready), 0);
    checkOutput("rst_dmrs_rd_addr", int'(bus.dmrs_rd_addr), 0);
    RST_RE = 1'b0;
    repeat (2) @(posedge CLK_RE);

    applyStimulus(0, 1, 2, 3, 1 << 2, 0, 0);
    applyStimulus(100, 2, 5, 5, 1 << 5, 1, 0);
    applyStimulus(1180, 2, 0, 1, 1, 0, 0);
    applyStimulus(1176, 2, 0, 1, 1, 0, 0);
    applyStimulus(1176, 1, 12, 13, 1 << 13, 1, 2);
    applyStimulus(50, 1, 7, 7, 0, 0, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 5, 4, 0, 0, 0);
    applyStimulus(0, 1, 3, 14, 0, 0, 0);
    for (int t = 0; t < 4; t++) begin
      int s0;
      s0 = int'($urandom_range(0, 13));
      applyStimulus(int'($urandom_range(0, 1100)), int'($urandom_range(1, 8)), s0,
                    s0 + int'($urandom_range(0, 13 - s0)), int'($urandom_range(0, 16383)),
                    int'($urandom_range(0, 1)), 0);
    end
    resetMidSlot();
    applyStimulus(200, 3, 1, 3, 1 << 2, 1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
